// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
//   ctrl_state_e : sequencer FSM states
//   pipe_ctrl_t  : one bundle of buffer-register enables and bubble-load flushes
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StDrain,
    StHalted
  } ctrl_state_e;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic mem_wb_we;
    logic if_id_flush;
    logic id_ex_flush;
  } pipe_ctrl_t;

  // Every register advances, nothing is squashed.
  localparam pipe_ctrl_t CtrlRun = '{
    pc_we:       1'b1,
    if_id_we:    1'b1,
    id_ex_we:    1'b1,
    ex_mem_we:   1'b1,
    mem_wb_we:   1'b1,
    if_id_flush: 1'b0,
    id_ex_flush: 1'b0
  };

  // Whole pipeline frozen.
  localparam pipe_ctrl_t CtrlHold = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: the load in EX writes a register the instruction in ID reads.
// Ports:
//   id_rs1, id_rs2 : source registers of the instruction in ID
//   ex_rd          : destination of the instruction in EX
//   ex_memread     : instruction in EX is a load
//   hazard         : one bubble is required
module load_use_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  output logic       hazard
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hazard = ex_memread & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Resolves load-use hazards, EX redirects,
// data-memory wait states and halt drain; keeps saturating stall/flush counters.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   id_rs1, id_rs2, id_halt        : ID-stage decode info
//   ex_rd, ex_memread, ex_redirect : EX-stage info
//   dmem_req, dmem_ready           : MEM-stage handshake
//   pc_we .. mem_wb_we             : buffer register enables
//   if_id_flush, id_ex_flush       : load a bubble instead of data
//   halted, mem_err                : sticky status
//   stall_cnt, flush_cnt           : saturating perf counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_halt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WaitW  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  ctrl_state_e       state_q, state_d;
  ctrl_state_e       ret_q, ret_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  pipe_ctrl_t ctrl, ctrl_out;
  logic       lu_hazard, mem_stall, drain_mode, stall_ev, flush_ev;

  load_use_detect u_load_use_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_rd      (ex_rd),
    .ex_memread (ex_memread),
    .hazard     (lu_hazard)
  );

  assign mem_stall = dmem_req & ~dmem_ready;
  // While waiting on memory, the decode follows the state we will return to.
  assign drain_mode = (state_q == StDrain) | ((state_q == StMemWait) & (ret_q == StDrain));

  always_comb begin
    ctrl      = CtrlRun;
    state_d   = state_q;
    ret_d     = ret_q;
    wait_d    = wait_q;
    drain_d   = drain_q;
    mem_err_d = mem_err_q;
    stall_ev  = 1'b0;
    flush_ev  = 1'b0;

    if (state_q == StHalted) begin
      ctrl = CtrlHold;
    end else if (mem_stall) begin
      ctrl     = CtrlHold;
      stall_ev = 1'b1;
      state_d  = StMemWait;
      if (state_q != StMemWait) begin
        ret_d = drain_mode ? StDrain : StRun;
      end
      if (MEM_TIMEOUT != 0) begin
        wait_d = wait_q + 1'b1;
        if (wait_d == WaitW'(MEM_TIMEOUT)) begin
          mem_err_d = 1'b1;
          state_d   = StHalted;
        end
      end
    end else begin
      wait_d = '0;
      if (ex_redirect) begin
        // Also cancels a drain: the halt in flight was on the wrong path.
        ctrl.if_id_flush = 1'b1;
        ctrl.id_ex_flush = 1'b1;
        flush_ev         = 1'b1;
        drain_d          = '0;
        state_d          = StRun;
      end else if (drain_mode) begin
        ctrl.pc_we       = 1'b0;
        ctrl.if_id_flush = 1'b1;
        drain_d          = drain_q + 1'b1;
        state_d          = (drain_d == DrainW'(DRAIN_CYCLES)) ? StHalted : StDrain;
      end else if (lu_hazard) begin
        ctrl.pc_we       = 1'b0;
        ctrl.if_id_we    = 1'b0;
        ctrl.id_ex_flush = 1'b1;
        stall_ev         = 1'b1;
        state_d          = StRun;
      end else if (id_halt) begin
        drain_d = '0;
        state_d = StDrain;
      end else begin
        state_d = StRun;
      end
    end

    stall_d = (stall_ev && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
    flush_d = (flush_ev && !(&flush_q)) ? flush_q + 1'b1 : flush_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StRun;
      ret_q     <= StRun;
      wait_q    <= '0;
      drain_q   <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      wait_q    <= wait_d;
      drain_q   <= drain_d;
      mem_err_q <= mem_err_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign ctrl_out    = reset ? CtrlHold : ctrl;
  assign pc_we       = ctrl_out.pc_we;
  assign if_id_we    = ctrl_out.if_id_we;
  assign id_ex_we    = ctrl_out.id_ex_we;
  assign ex_mem_we   = ctrl_out.ex_mem_we;
  assign mem_wb_we   = ctrl_out.mem_wb_we;
  assign if_id_flush = ctrl_out.if_id_flush;
  assign id_ex_flush = ctrl_out.id_ex_flush;
  assign halted      = (state_q == StHalted) & ~reset;
  assign mem_err     = mem_err_q & ~reset;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (MEM_TIMEOUT reduced to 8, DRAIN_CYCLES 3).
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_halt, ex_memread, ex_redirect, dmem_req, dmem_ready;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush;
  logic        halted, mem_err;
  logic [15:0] stall_cnt, flush_cnt;
  logic [6:0]  ctrl_vec;

  int n_assert = 0;
  int n_fail   = 0;

  // {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush}
  localparam logic [6:0] ExpRun   = 7'b1111100;
  localparam logic [6:0] ExpHold  = 7'b0000000;
  localparam logic [6:0] ExpLu    = 7'b0011101;
  localparam logic [6:0] ExpRedir = 7'b1111111;
  localparam logic [6:0] ExpDrain = 7'b0111110;

  pipeline_ctrl #(
    .CNT_W        (16),
    .DRAIN_CYCLES (3),
    .MEM_TIMEOUT  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_halt     (id_halt),
    .ex_rd       (ex_rd),
    .ex_memread  (ex_memread),
    .ex_redirect (ex_redirect),
    .dmem_req    (dmem_req),
    .dmem_ready  (dmem_ready),
    .pc_we       (pc_we),
    .if_id_we    (if_id_we),
    .id_ex_we    (id_ex_we),
    .ex_mem_we   (ex_mem_we),
    .mem_wb_we   (mem_wb_we),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .halted      (halted),
    .mem_err     (mem_err),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  assign ctrl_vec = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; id_halt = 1'b0;
    ex_memread = 1'b0; ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    #1;
    chk("rst_ctrl", {25'd0, ctrl_vec}, {25'd0, ExpHold});
    tick();
    reset = 1'b0;
    #1;
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    chk("rst_status", {30'd0, halted, mem_err}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    tick();
    do_reset();

    // Load to x0 never stalls.
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; #1;
    chk("x0_no_stall", {25'd0, ctrl_vec}, {25'd0, ExpRun});
    tick();
    chk("x0_stall_cnt", {16'd0, stall_cnt}, 32'd0);

    // Load-use on rs2: one bubble, then the hazard clears.
    ex_rd = 5'd5; id_rs2 = 5'd5; id_rs1 = 5'd1; #1;
    chk("lu_bubble", {25'd0, ctrl_vec}, {25'd0, ExpLu});
    tick();
    ex_memread = 1'b0; ex_rd = 5'd0; #1;
    chk("lu_release", {25'd0, ctrl_vec}, {25'd0, ExpRun});
    chk("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);

    // Redirect outranks a pending load-use.
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; ex_redirect = 1'b1; #1;
    chk("redir_over_lu", {25'd0, ctrl_vec}, {25'd0, ExpRedir});
    tick();
    clear_inputs(); #1;
    chk("redir_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    chk("redir_stall_cnt", {16'd0, stall_cnt}, 32'd0);

    // Four memory wait cycles, release on the fifth.
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mem_hold_%0d", i), {25'd0, ctrl_vec}, {25'd0, ExpHold});
      tick();
    end
    dmem_ready = 1'b1; #1;
    chk("mem_release", {25'd0, ctrl_vec}, {25'd0, ExpRun});
    tick();
    clear_inputs(); #1;
    chk("mem_stall_cnt", {16'd0, stall_cnt}, 32'd4);
    chk("mem_no_err", {30'd0, halted, mem_err}, 32'd0);

    // Memory timeout after 8 wait cycles.
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("tmo_not_halted_%0d", i), {31'd0, halted}, 32'd0);
      tick();
    end
    chk("tmo_status", {30'd0, halted, mem_err}, 32'd3);
    chk("tmo_ctrl", {25'd0, ctrl_vec}, {25'd0, ExpHold});
    tick();
    tick();
    chk("tmo_stall_frozen", {16'd0, stall_cnt}, 32'd8);

    // Halt: entry cycle plus three drain cycles.
    do_reset();
    id_halt = 1'b1; #1;
    chk("halt_entry", {25'd0, ctrl_vec}, {25'd0, ExpRun});
    tick();
    id_halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("drain_ctrl_%0d", i), {25'd0, ctrl_vec}, {25'd0, ExpDrain});
      chk($sformatf("drain_not_halted_%0d", i), {31'd0, halted}, 32'd0);
      tick();
    end
    chk("halt_done", {31'd0, halted}, 32'd1);
    chk("halt_ctrl", {25'd0, ctrl_vec}, {25'd0, ExpHold});
    chk("halt_no_err", {31'd0, mem_err}, 32'd0);

    // Redirect in the first drain cycle cancels the halt.
    do_reset();
    id_halt = 1'b1;
    tick();
    id_halt = 1'b0; ex_redirect = 1'b1; #1;
    chk("drain_redir", {25'd0, ctrl_vec}, {25'd0, ExpRedir});
    tick();
    ex_redirect = 1'b0; #1;
    chk("drain_cancel_run", {25'd0, ctrl_vec}, {25'd0, ExpRun});
    tick(); tick(); tick(); tick();
    chk("drain_cancel_not_halted", {31'd0, halted}, 32'd0);
    chk("drain_cancel_flush_cnt", {16'd0, flush_cnt}, 32'd1);

    // Memory stall mid-drain resumes the drain afterwards.
    do_reset();
    id_halt = 1'b1;
    tick();
    id_halt = 1'b0;
    tick();
    dmem_req = 1'b1; dmem_ready = 1'b0; #1;
    chk("drain_mem_hold", {25'd0, ctrl_vec}, {25'd0, ExpHold});
    tick();
    dmem_ready = 1'b1; #1;
    chk("drain_mem_resume", {25'd0, ctrl_vec}, {25'd0, ExpDrain});
    tick();
    clear_inputs(); #1;
    chk("drain_last", {25'd0, ctrl_vec}, {25'd0, ExpDrain});
    chk("drain_last_not_halted", {31'd0, halted}, 32'd0);
    tick();
    chk("drain_mem_halted", {31'd0, halted}, 32'd1);
    chk("drain_mem_stall_cnt", {16'd0, stall_cnt}, 32'd1);

    // Reset releases a halted core.
    do_reset();
    #1;
    chk("post_halt_run", {25'd0, ctrl_vec}, {25'd0, ExpRun});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
